instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Sequential RV32I instruction encoder: the inverse of the main decoder.
- Accepts field-level requests (kind, registers, funct, immediate) over valid/ready and packs them into 32-bit LW, SW, R-type and BEQ words.
- Encoded words are buffered in an output FIFO.
- Used by the pipeline testbench and the instruction-memory loader to generate instruction streams for the pipelined core.

Parameters:
- DEPTH, 4, output FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of the encoded-instruction and error counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- kind  input  2  0=LW, 1=SW, 2=R-type, 3=BEQ.
- rd  input  5  destination register; LW and R-type only.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2; SW, R-type and BEQ only.
- funct3  input  3  R-type only.
- funct7  input  7  R-type only.
- imm  input  13  signed immediate; 12-bit field for LW/SW, byte offset for BEQ.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- instr  output  32  FIFO head word; 0 when empty.
- err  output  1  one-cycle pulse for a rejected request.
- enc_count  output  CNT_W  words written to the FIFO; wraps.
- err_count  output  CNT_W  rejected requests; saturates at all-ones.

Behaviour:
- Reset: FIFO pointers and occupancy cleared; out_valid=0, instr=0, err=0, enc_count=0, err_count=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: all buffered words are discarded and no err pulse is issued.
- in_ready = !full.
  - Depends only on occupancy, never on out_ready.
  - A pop and push in the same cycle when full is therefore impossible; push is blocked that cycle.
- Encoding is combinational from the request fields and written to the FIFO on the accept edge.
  - out_valid rises on the cycle after acceptance when the FIFO was empty: latency 1.
- LW: imm[11:0], rs1, 3'b010, rd, 7'b0000011.
- SW: imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011.
- R-type: funct7, rs2, rs1, funct3, rd, 7'b0110011.
- BEQ: imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011.
- Field handling: funct3 and funct7 are ignored except for R-type. rd is ignored for SW and BEQ.
- Reject conditions:
  - LW/SW with imm[12] != imm[11] (outside the 12-bit signed range).
  - BEQ with imm[0]=1 (misaligned).
- Rejected requests:
  - The handshake still completes, so in_ready is unaffected.
  - Nothing is written to the FIFO.
  - err pulses high for exactly the next cycle and err_count increments.
- enc_count increments on every FIFO write and wraps modulo 2^CNT_W.
- Pop occurs when out_valid & out_ready.
- Push and pop in the same cycle (not full, not empty): occupancy unchanged, order preserved.
- Pointers wrap modulo DEPTH. Strict FIFO order.
- instr and out_valid are stable while out_valid=1 and out_ready=0.

Test Plan:
- LW rd=5, rs1=2, imm=8 -> instr=0x00812283 one cycle after accept, enc_count=1.
- SW rs2=5, rs1=2, imm=12 -> 0x00512623. ADD (kind=2, funct3=0, funct7=0) rd=3, rs1=1, rs2=2 -> 0x002081B3.
- BEQ rs1=1, rs2=2, imm=-4 (13'h1FFC) -> 0xFE208EE3.
- BEQ imm=3 -> no out_valid, err high one cycle, err_count=1. LW imm=13'h0800 -> rejected, err_count=2.
- out_ready=0, DEPTH=4, push 5 LWs:
  - in_ready=0 after the 4th accept and the 5th request is held.
  - Raise out_ready -> 5 words emerge in order, enc_count=5.
- Assert rst while the FIFO holds 3 words -> next cycle out_valid=0, instr=0, both counters 0, in_ready=1.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-level encoder: packs LW/SW/R-type/BEQ requests into 32-bit words
// and queues them in a small FIFO for the downstream consumer.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       kind,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [12:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_err;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_reject;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;

  // Handshakes are strict valid/ready: a transfer happens on a rising edge where
  // both are high. in_ready depends only on FIFO occupancy, so a full FIFO blocks
  // the push even if the head is popped that same cycle. Rejected requests still
  // complete their handshake but are never written.
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign in_ready  = !w_full;
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && !w_reject;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign instr     = w_empty ? 32'd0 : r_mem[r_rd_ptr];
  assign err       = r_err;
  assign enc_count = r_enc_cnt;
  assign err_count = r_err_cnt;

  always_comb begin
    w_word   = 32'd0;
    w_reject = 1'b0;
    case (kind)
      2'd0: begin
        w_word   = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
        w_reject = (imm[12] != imm[11]);
      end
      2'd1: begin
        w_word   = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
        w_reject = (imm[12] != imm[11]);
      end
      2'd2: begin
        w_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      end
      default: begin
        w_word   = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        w_reject = imm[0];
      end
    endcase
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_enc_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_accept && w_reject;
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_enc_cnt <= r_enc_cnt + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_accept && w_reject && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, reject handling, FIFO
// back-pressure with in-order drain, and reset while words are buffered.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       kind = '0;
  logic [4:0]       rd = '0;
  logic [4:0]       rs1 = '0;
  logic [4:0]       rs2 = '0;
  logic [2:0]       funct3 = '0;
  logic [6:0]       funct7 = '0;
  logic [12:0]      imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      instr;
  logic             err;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .kind(kind), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err(err), .enc_count(enc_count), .err_count(err_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  int exp_enc = 0;
  int exp_errc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called on a negedge; returns on the negedge right after the accepting edge.
  task automatic send(input logic [1:0] k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] im);
    int waits;
    kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    waits = 0;
    while (!in_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", waits);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [12:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  // LW rd=k, rs1=0, imm=0 used for the back-pressure and reset sequences
  logic [31:0] lw_words[5];

  initial begin
    vecs[0]  = '{2'd0, 5'd5,  5'd2, 5'd0,  3'd0, 7'h00, 13'h0008, 32'h00812283, 1'b0};
    vecs[1]  = '{2'd1, 5'd0,  5'd2, 5'd5,  3'd0, 7'h00, 13'h000C, 32'h00512623, 1'b0};
    vecs[2]  = '{2'd2, 5'd3,  5'd1, 5'd2,  3'd0, 7'h00, 13'h0000, 32'h002081B3, 1'b0};
    vecs[3]  = '{2'd3, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 13'h1FFC, 32'hFE208EE3, 1'b0};
    vecs[4]  = '{2'd3, 5'd0,  5'd1, 5'd2,  3'd0, 7'h00, 13'h0003, 32'h00000000, 1'b1};
    vecs[5]  = '{2'd0, 5'd5,  5'd2, 5'd0,  3'd0, 7'h00, 13'h0800, 32'h00000000, 1'b1};
    vecs[6]  = '{2'd2, 5'd1,  5'd2, 5'd3,  3'd0, 7'h20, 13'h0000, 32'h403100B3, 1'b0};
    vecs[7]  = '{2'd0, 5'd1,  5'd0, 5'd31, 3'd7, 7'h7F, 13'h1FFF, 32'hFFF02083, 1'b0};
    vecs[8]  = '{2'd1, 5'd31, 5'd2, 5'd5,  3'd5, 7'h7F, 13'h000C, 32'h00512623, 1'b0};
    vecs[9]  = '{2'd3, 5'd31, 5'd0, 5'd0,  3'd7, 7'h7F, 13'h0FFE, 32'h7E000FE3, 1'b0};
    vecs[10] = '{2'd1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 13'h1800, 32'h80002023, 1'b0};
    vecs[11] = '{2'd1, 5'd0,  5'd0, 5'd0,  3'd0, 7'h00, 13'h1000, 32'h00000000, 1'b1};
    lw_words[0] = 32'h00002083;
    lw_words[1] = 32'h00002103;
    lw_words[2] = 32'h00002183;
    lw_words[3] = 32'h00002203;
    lw_words[4] = 32'h00002283;
  end

  // ---------------- test sequence ----------------
  initial begin
    int got;
    bit accept_pending;
    @(negedge clk);
    do_reset();

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instr",     instr,          32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Table: each request is accepted, checked one cycle later, then drained.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
           vecs[i].f3, vecs[i].f7, vecs[i].imm);
      if (vecs[i].exp_err) begin
        exp_errc++;
        check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd0);
        check($sformatf("v%0d_err", i),       32'(err),       32'd1);
        check($sformatf("v%0d_err_count", i), 32'(err_count), 32'(exp_errc));
        check($sformatf("v%0d_enc_count", i), 32'(enc_count), 32'(exp_enc));
        @(negedge clk);
        check($sformatf("v%0d_err_drop", i),  32'(err),       32'd0);
      end else begin
        exp_enc++;
        exp_q.push_back(vecs[i].exp_instr);
        check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_instr", i),     instr,          exp_q.pop_front());
        check($sformatf("v%0d_err", i),       32'(err),       32'd0);
        check($sformatf("v%0d_enc_count", i), 32'(enc_count), 32'(exp_enc));
        pop_one();
        check($sformatf("v%0d_drained", i),   32'(out_valid), 32'd0);
        check($sformatf("v%0d_instr_zero", i), instr,         32'd0);
      end
    end

    // Back-pressure: fill the FIFO, hold a fifth request, then drain in order.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      send(2'd0, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
      exp_q.push_back(lw_words[k]);
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_instr",    instr,         lw_words[0]);
    kind = 2'd0; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0; imm = 13'd0;
    funct3 = 3'd0; funct7 = 7'd0;
    in_valid = 1'b1;
    exp_q.push_back(lw_words[4]);
    repeat (3) begin
      @(negedge clk);
      check("held_in_ready",  32'(in_ready),  32'd0);
      check("held_enc_count", 32'(enc_count), 32'd4);
      check("held_instr",     instr,          lw_words[0]);
    end
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      accept_pending = in_valid && in_ready;
      if (out_valid) begin
        check($sformatf("drain_%0d", got), instr, exp_q.pop_front());
        got++;
      end
      @(negedge clk);
      if (accept_pending) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    check("drain_words",     32'(got),       32'd5);
    check("drain_enc_count", 32'(enc_count), 32'd5);
    check("drain_empty",     32'(out_valid), 32'd0);
    check("drain_in_valid",  32'(in_valid),  32'd0);

    // Reset with three buffered words and a rejected request on the reset edge.
    send(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0800);
    for (int k = 0; k < 3; k++) begin
      send(2'd0, 5'(k + 1), 5'd0, 5'd0, 3'd0, 7'd0, 13'd0);
    end
    check("pre_rst_err_count", 32'(err_count), 32'd1);
    check("pre_rst_enc_count", 32'(enc_count), 32'd8);
    kind = 2'd3; imm = 13'h0001; in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_instr",     instr,          32'd0);
    check("mid_rst_enc_count", 32'(enc_count), 32'd0);
    check("mid_rst_err_count", 32'(err_count), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_err",       32'(err),       32'd0);
    @(negedge clk);
    check("mid_rst_err_next",  32'(err),       32'd0);
    check("mid_rst_still_empty", 32'(out_valid), 32'd0);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
